// File: rtl/lockin_sweep_ctrl.sv
//==============================================================================
// Module      : lockin_sweep_ctrl
// Description : Lock-in frequency sweep sequencer. Steps the DDS increment,
//               averages |x|+|y| per step and parks on the largest response.
//               Optional per-step result stream: LOCKIN_STEP_STREAM_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lockin_sweep_ctrl #(
   parameter int COUNTER_LENGTH = 32,
   parameter int CART_LENGTH    = 24,
   parameter int AVG_LOG2       = 8,
   parameter int STEP_LENGTH    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      abort,
   input  logic [COUNTER_LENGTH-1:0] inc_start,
   input  logic [COUNTER_LENGTH-1:0] inc_step,
   input  logic [STEP_LENGTH-1:0]    n_steps,
   input  logic [STEP_LENGTH-1:0]    settle_cycles,
   input  logic [CART_LENGTH-1:0]    x_in,
   input  logic [CART_LENGTH-1:0]    y_in,
   output logic [COUNTER_LENGTH-1:0] inc_out,
   output logic                      sync_out,
   output logic                      busy,
   output logic                      done,
   output logic                      locked,
   output logic [COUNTER_LENGTH-1:0] peak_inc,
   output logic [CART_LENGTH:0]      peak_mag
`ifdef LOCKIN_STEP_STREAM_EN
   ,
   output logic                      step_valid,
   output logic [COUNTER_LENGTH-1:0] step_inc,
   output logic [CART_LENGTH:0]      step_mag
`endif
);

   localparam int c_MAG_W = CART_LENGTH + 1;
   localparam int c_ACC_W = CART_LENGTH + 1 + AVG_LOG2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SYNC   = 3'd1,
      S_SETTLE = 3'd2,
      S_ACCUM  = 3'd3,
      S_EVAL   = 3'd4,
      S_LOCK   = 3'd5
   } state_t;

   state_t                    r_state,      w_state_nxt;
   logic [COUNTER_LENGTH-1:0] r_inc,        w_inc_nxt;
   logic                      r_sync,       w_sync_nxt;
   logic                      r_busy;
   logic                      r_done,       w_done_nxt;
   logic                      r_locked,     w_locked_nxt;
   logic [COUNTER_LENGTH-1:0] r_peak_inc,   w_peak_inc_nxt;
   logic [c_MAG_W-1:0]        r_peak_mag,   w_peak_mag_nxt;
   logic [COUNTER_LENGTH-1:0] r_inc_step,   w_inc_step_nxt;
   logic [STEP_LENGTH-1:0]    r_n_steps,    w_n_steps_nxt;
   logic [STEP_LENGTH-1:0]    r_settle,     w_settle_nxt;
   logic [STEP_LENGTH-1:0]    r_step,       w_step_nxt;
   logic [STEP_LENGTH-1:0]    r_settle_cnt, w_settle_cnt_nxt;
   logic [AVG_LOG2-1:0]       r_acc_cnt,    w_acc_cnt_nxt;
   logic [c_ACC_W-1:0]        r_acc,        w_acc_nxt;
   logic                      r_step_valid, w_step_valid_nxt;
   logic [COUNTER_LENGTH-1:0] r_step_inc,   w_step_inc_nxt;
   logic [c_MAG_W-1:0]        r_step_mag,   w_step_mag_nxt;

   // Two's-complement negation in CART_LENGTH bits yields the exact unsigned
   // magnitude, including for the most negative input.
   logic [CART_LENGTH-1:0] w_abs_x, w_abs_y;
   logic [c_MAG_W-1:0]     w_sample;
   logic [c_ACC_W-1:0]     w_acc_sum;
   logic [c_MAG_W-1:0]     w_mean;
   logic                   w_take;

   assign w_abs_x   = x_in[CART_LENGTH-1] ? (~x_in + CART_LENGTH'(1)) : x_in;
   assign w_abs_y   = y_in[CART_LENGTH-1] ? (~y_in + CART_LENGTH'(1)) : y_in;
   assign w_sample  = {1'b0, w_abs_x} + {1'b0, w_abs_y};
   assign w_acc_sum = r_acc + {{AVG_LOG2{1'b0}}, w_sample};
   assign w_mean    = r_acc[c_ACC_W-1:AVG_LOG2];
   assign w_take    = (r_step == '0) || (w_mean > r_peak_mag);

   always_comb begin
      w_state_nxt      = r_state;
      w_inc_nxt        = r_inc;
      w_sync_nxt       = 1'b0;
      w_done_nxt       = 1'b0;
      w_locked_nxt     = r_locked;
      w_peak_inc_nxt   = r_peak_inc;
      w_peak_mag_nxt   = r_peak_mag;
      w_inc_step_nxt   = r_inc_step;
      w_n_steps_nxt    = r_n_steps;
      w_settle_nxt     = r_settle;
      w_step_nxt       = r_step;
      w_settle_cnt_nxt = r_settle_cnt;
      w_acc_cnt_nxt    = r_acc_cnt;
      w_acc_nxt        = r_acc;
      w_step_valid_nxt = 1'b0;
      w_step_inc_nxt   = r_step_inc;
      w_step_mag_nxt   = r_step_mag;

      case (r_state)
         S_IDLE: begin
            if (abort) begin
               w_locked_nxt = 1'b0;
            end else if (start) begin
               w_locked_nxt   = 1'b0;
               w_inc_step_nxt = inc_step;
               w_n_steps_nxt  = n_steps;
               w_settle_nxt   = settle_cycles;
               if (n_steps == '0) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_state_nxt    = S_SYNC;
                  w_sync_nxt     = 1'b1;
                  w_inc_nxt      = inc_start;
                  w_step_nxt     = '0;
                  w_peak_inc_nxt = '0;
                  w_peak_mag_nxt = '0;
                  w_acc_nxt      = '0;
                  w_acc_cnt_nxt  = '0;
               end
            end
         end
         S_SYNC: begin
            w_settle_cnt_nxt = r_settle;
            w_state_nxt      = S_SETTLE;
         end
         S_SETTLE: begin
            if (r_settle_cnt == '0) begin
               w_state_nxt   = S_ACCUM;
               w_acc_cnt_nxt = '0;
            end else begin
               w_settle_cnt_nxt = r_settle_cnt - STEP_LENGTH'(1);
            end
         end
         S_ACCUM: begin
            w_acc_nxt     = w_acc_sum;
            w_acc_cnt_nxt = r_acc_cnt + AVG_LOG2'(1);
            if (&r_acc_cnt) begin
               w_state_nxt = S_EVAL;
               // Published during EVAL, so the mean includes this last sample.
               w_step_valid_nxt = 1'b1;
               w_step_inc_nxt   = r_inc;
               w_step_mag_nxt   = w_acc_sum[c_ACC_W-1:AVG_LOG2];
            end
         end
         S_EVAL: begin
            if (w_take) begin
               w_peak_inc_nxt = r_inc;
               w_peak_mag_nxt = w_mean;
            end
            w_acc_nxt = '0;
            if (r_step == r_n_steps - STEP_LENGTH'(1)) begin
               w_state_nxt  = S_LOCK;
               w_inc_nxt    = w_peak_inc_nxt;
               w_sync_nxt   = 1'b1;
               w_done_nxt   = 1'b1;
               w_locked_nxt = 1'b1;
            end else begin
               w_state_nxt = S_SYNC;
               w_sync_nxt  = 1'b1;
               w_inc_nxt   = r_inc + r_inc_step;
               w_step_nxt  = r_step + STEP_LENGTH'(1);
            end
         end
         S_LOCK: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Abort wins over every transition; partial results are left in place.
      if (abort && (r_state != S_IDLE)) begin
         w_state_nxt      = S_IDLE;
         w_inc_nxt        = r_inc;
         w_sync_nxt       = 1'b0;
         w_done_nxt       = 1'b0;
         w_locked_nxt     = 1'b0;
         w_peak_inc_nxt   = r_peak_inc;
         w_peak_mag_nxt   = r_peak_mag;
         w_step_valid_nxt = 1'b0;
         w_step_inc_nxt   = r_step_inc;
         w_step_mag_nxt   = r_step_mag;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_inc        <= '0;
         r_sync       <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_locked     <= 1'b0;
         r_peak_inc   <= '0;
         r_peak_mag   <= '0;
         r_inc_step   <= '0;
         r_n_steps    <= '0;
         r_settle     <= '0;
         r_step       <= '0;
         r_settle_cnt <= '0;
         r_acc_cnt    <= '0;
         r_acc        <= '0;
         r_step_valid <= 1'b0;
         r_step_inc   <= '0;
         r_step_mag   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_inc        <= w_inc_nxt;
         r_sync       <= w_sync_nxt;
         r_busy       <= (w_state_nxt != S_IDLE);
         r_done       <= w_done_nxt;
         r_locked     <= w_locked_nxt;
         r_peak_inc   <= w_peak_inc_nxt;
         r_peak_mag   <= w_peak_mag_nxt;
         r_inc_step   <= w_inc_step_nxt;
         r_n_steps    <= w_n_steps_nxt;
         r_settle     <= w_settle_nxt;
         r_step       <= w_step_nxt;
         r_settle_cnt <= w_settle_cnt_nxt;
         r_acc_cnt    <= w_acc_cnt_nxt;
         r_acc        <= w_acc_nxt;
         r_step_valid <= w_step_valid_nxt;
         r_step_inc   <= w_step_inc_nxt;
         r_step_mag   <= w_step_mag_nxt;
      end
   end

   assign inc_out  = r_inc;
   assign sync_out = r_sync;
   assign busy     = r_busy;
   assign done     = r_done;
   assign locked   = r_locked;
   assign peak_inc = r_peak_inc;
   assign peak_mag = r_peak_mag;

`ifdef LOCKIN_STEP_STREAM_EN
   assign step_valid = r_step_valid;
   assign step_inc   = r_step_inc;
   assign step_mag   = r_step_mag;
`else
   // Stream registers are unloaded without the stream ports and get trimmed.
   logic w_stream_unused;
   assign w_stream_unused = r_step_valid ^ (^r_step_inc) ^ (^r_step_mag);
`endif

endmodule

`default_nettype wire

// File: tb/tb_lockin_sweep_ctrl.sv
//==============================================================================
// Module      : tb_lockin_sweep_ctrl
// Description : Directed self-checking bench for lockin_sweep_ctrl (AVG_LOG2=2).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_lockin_sweep_ctrl;

   localparam int CL = 32;
   localparam int XL = 24;
   localparam int AL = 2;
   localparam int SL = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [CL-1:0] inc_start = '0;
   logic [CL-1:0] inc_step = '0;
   logic [SL-1:0] n_steps = '0;
   logic [SL-1:0] settle_cycles = '0;
   logic [XL-1:0] x_drv = '0;
   logic [XL-1:0] y_drv = '0;
   logic          basic_mode = 1'b0;
   logic [XL-1:0] x_in, y_in;
   logic [CL-1:0] inc_out, peak_inc;
   logic          sync_out, busy, done, locked;
   logic [XL:0]   peak_mag;
`ifdef LOCKIN_STEP_STREAM_EN
   logic          step_valid;
   logic [CL-1:0] step_inc;
   logic [XL:0]   step_mag;
`endif

   // Basic sweep: response only at the third point (increment 120).
   assign x_in = basic_mode ? ((inc_out == 32'd120) ? 24'd1000     : 24'd0) : x_drv;
   assign y_in = basic_mode ? ((inc_out == 32'd120) ? 24'hFFFE0C   : 24'd0) : y_drv;

   lockin_sweep_ctrl #(
      .COUNTER_LENGTH(CL), .CART_LENGTH(XL), .AVG_LOG2(AL), .STEP_LENGTH(SL)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .inc_start(inc_start), .inc_step(inc_step), .n_steps(n_steps),
      .settle_cycles(settle_cycles), .x_in(x_in), .y_in(y_in),
      .inc_out(inc_out), .sync_out(sync_out), .busy(busy), .done(done),
      .locked(locked), .peak_inc(peak_inc), .peak_mag(peak_mag)
`ifdef LOCKIN_STEP_STREAM_EN
      , .step_valid(step_valid), .step_inc(step_inc), .step_mag(step_mag)
`endif
   );

   always #5 clk = ~clk;

   int            cyc = 0;
   int            n_checks = 0;
   int            n_errors = 0;
   int            sync_n = 0;
   logic [CL-1:0] sync_log [16];
   int            done_n = 0;
   int            done_edge = 0;
   int            sv_n = 0;
   logic          busy_seen = 1'b0;
   int            start_edge = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (sync_out) begin
         if (sync_n < 16) sync_log[sync_n] = inc_out;
         sync_n = sync_n + 1;
      end
      if (done) begin
         done_n    = done_n + 1;
         done_edge = cyc;
      end
      if (busy) busy_seen = 1'b1;
`ifdef LOCKIN_STEP_STREAM_EN
      if (step_valid) sv_n = sv_n + 1;
`endif
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      sync_n    = 0;
      sv_n      = 0;
      busy_seen = 1'b0;
   endtask

   // Pulses start for one edge, then scrambles the setup inputs.
   task automatic pulse_start(input logic [CL-1:0] s, input logic [CL-1:0] st,
                              input logic [SL-1:0] n, input logic [SL-1:0] se);
      inc_start     = s;
      inc_step      = st;
      n_steps       = n;
      settle_cycles = se;
      start         = 1'b1;
      @(posedge clk);
      #1;
      start_edge    = cyc;
      start         = 1'b0;
      inc_start     = 32'hDEAD_BEEF;
      inc_step      = 32'h0000_1234;
      n_steps       = 16'd7;
      settle_cycles = 16'd9;
   endtask

   task automatic wait_done(input string tag, input int limit);
      int base;
      base = done_n;
      for (int i = 0; i < limit && done_n == base; i++) tick();
      check(tag, 64'(done_n - base), 64'd1);
   endtask

   initial begin
      // Power-on reset
      repeat (3) tick();
      check("rst_inc_out", 64'(inc_out), 64'd0);
      check("rst_flags", 64'({sync_out, busy, done, locked}), 64'd0);
      check("rst_peak", 64'({peak_inc, peak_mag}), 64'd0);
      rst = 1'b1;
      repeat (2) tick();

      // Reset asserted while accumulating
      pulse_start(32'd5, 32'd1, 16'd4, 16'd2);
      repeat (5) tick();
      check("mid_busy", 64'(busy), 64'd1);
      check("mid_inc", 64'(inc_out), 64'd5);
      rst = 1'b0;
      #1;
      check("mid_rst_inc_out", 64'(inc_out), 64'd0);
      check("mid_rst_flags", 64'({sync_out, busy, done, locked}), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (3) tick();
      check("post_rst_busy", 64'(busy), 64'd0);

      // Basic sweep
      clear_log();
      basic_mode = 1'b1;
      pulse_start(32'd100, 32'd10, 16'd4, 16'd2);
      check("basic_busy_rise", 64'(busy), 64'd1);
      check("basic_first_inc", 64'(inc_out), 64'd100);
      wait_done("basic_done_seen", 100);
      check("basic_done_lat", 64'(done_edge - start_edge), 64'd36);
      check("basic_sync_cnt", 64'(sync_n), 64'd5);
      check("basic_inc_seq", {sync_log[0][15:0], sync_log[1][15:0], sync_log[2][15:0], sync_log[3][15:0]},
            {16'd100, 16'd110, 16'd120, 16'd130});
      check("basic_lock_inc", 64'(sync_log[4]), 64'd120);
      check("basic_peak_mag", 64'(peak_mag), 64'd1500);
      check("basic_peak_inc", 64'(peak_inc), 64'd120);
      check("basic_after", 64'({busy, done, locked}), 64'b001);
      check("basic_inc_park", 64'(inc_out), 64'd120);
`ifdef LOCKIN_STEP_STREAM_EN
      check("basic_step_valid_cnt", 64'(sv_n), 64'd4);
`endif
      basic_mode = 1'b0;

      // Tie and wrap
      clear_log();
      x_drv = 24'd7;
      y_drv = 24'd0;
      pulse_start(32'hFFFF_FFF8, 32'd8, 16'd3, 16'd0);
      wait_done("tie_done_seen", 100);
      check("tie_done_lat", 64'(done_edge - start_edge), 64'd21);
      check("tie_wrap_inc", 64'(sync_log[1]), 64'd0);
      check("tie_third_inc", 64'(sync_log[2]), 64'd8);
      check("tie_peak_inc", 64'(peak_inc), 64'hFFFF_FFF8);
      check("tie_peak_mag", 64'(peak_mag), 64'd7);
      check("tie_locked", 64'(locked), 64'd1);

      // Zero steps: immediate done, clears locked, no sweep
      clear_log();
      pulse_start(32'd77, 32'd1, 16'd0, 16'd0);
      check("zero_done", 64'({done, busy, locked}), 64'b100);
      tick();
      check("zero_done_pulse", 64'(done), 64'd0);
      repeat (3) tick();
      check("zero_no_busy_sync", 64'({busy_seen, 31'(sync_n)}), 64'd0);
`ifdef LOCKIN_STEP_STREAM_EN
      check("zero_step_valid", 64'(sv_n), 64'd0);
`endif

      // Most negative inputs on both channels
      x_drv = 24'h800000;
      y_drv = 24'h800000;
      pulse_start(32'd50, 32'd5, 16'd2, 16'd1);
      wait_done("ext_done_seen", 100);
      check("ext_peak_mag", 64'(peak_mag), 64'd16777216);
      check("ext_peak_inc", 64'(peak_inc), 64'd50);

      // start together with abort in IDLE
      clear_log();
      abort = 1'b1;
      pulse_start(32'd300, 32'd1, 16'd2, 16'd0);
      abort = 1'b0;
      check("sa_idle", 64'({busy, locked, sync_out}), 64'd0);
      repeat (3) tick();
      check("sa_no_sync", 64'(sync_n), 64'd0);

      // Abort in step 1 SETTLE; start while busy is ignored
      clear_log();
      x_drv = 24'd3;
      y_drv = 24'd0;
      begin
         int dn0;
         dn0 = done_n;
         pulse_start(32'd200, 32'd20, 16'd4, 16'd3);
         repeat (3) tick();
         inc_start = 32'd999;
         n_steps   = 16'd1;
         start     = 1'b1;
         tick();
         start     = 1'b0;
         repeat (8) tick();
         check("ab_pre_state", 64'({busy, sync_out}), 64'b10);
         check("ab_pre_inc", 64'(inc_out), 64'd220);
         abort = 1'b1;
         tick();
         abort = 1'b0;
         check("ab_idle", 64'({busy, locked, done}), 64'd0);
         check("ab_inc_hold", 64'(inc_out), 64'd220);
         check("ab_peak_hold", 64'({peak_inc, peak_mag}), {32'd200, 25'd3});
         repeat (10) tick();
         check("ab_no_done", 64'(done_n - dn0), 64'd0);
         check("ab_sync_cnt", 64'(sync_n), 64'd2);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
